dm_port_arbiter: RTL and testbench

Arbiter and write-buffer controller for the single-ported data memory shared by the load/store unit. It accepts load requests and committed stores. Committed stores are held in a small in-order write buffer, and each cycle the block grants the DM port to either one load read or one buffered-store write. Loads have priority. Stores are drained when the port is idle, when the buffer is full, when a load conflicts with a buffered store, or when stores have been starved too long. The block sits between the LSU queues and the DM macro.

---
 rtl/dm_port_arbiter_pkg.sv | 21 ++
 rtl/dm_port_arbiter_wb_fifo.sv | 85 ++++++++
 rtl/dm_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_dm_port_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/dm_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter and its write buffer.
// Optional store-to-load forwarding is enabled by defining DM_ARB_FWD_EN.
package dm_port_arbiter_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] wmask;
    logic        valid;
  } wb_entry_t;

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_LOAD,
    GNT_DRAIN
  } grant_e;

  // Active-low bit mask meaning "write nothing".
  localparam logic [31:0] MASK_NONE = 32'hFFFF_FFFF;

endpackage

// File: rtl/dm_port_arbiter_wb_fifo.sv
// In-order circular write buffer: exposes head entry, count and a per-entry word match vector.
// With DM_ARB_FWD_EN defined it also reports the youngest matching entry for forwarding.
module wb_fifo
  import dm_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [31:0]      push_addr_i,
  input  logic [31:0]      push_wdata_i,
  input  logic [31:0]      push_wmask_i,
  input  logic             pop_i,
  input  logic [29:0]      match_word_i,
  output wb_entry_t        head_o,
  output logic [CW-1:0]    count_o,
  output logic [DEPTH-1:0] match_o
`ifdef DM_ARB_FWD_EN
  ,
  output logic             fwd_hit_o,
  output logic [31:0]      fwd_wdata_o,
  output logic [31:0]      fwd_wmask_o
`endif
);

  wb_entry_t         mem_q [DEPTH];
  logic [PW-1:0]     head_q, tail_q;
  logic [CW-1:0]     count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_i) begin
        mem_q[tail_q] <= '{addr: push_addr_i, wdata: push_wdata_i,
                           wmask: push_wmask_i, valid: 1'b1};
        tail_q <= tail_q + 1'b1;
      end
      if (pop_i) begin
        mem_q[head_q].valid <= 1'b0;
        head_q <= head_q + 1'b1;
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[head_q];
  assign count_o = count_q;

  always_comb begin
    match_o = '0;
    for (int i = 0; i < DEPTH; i++)
      match_o[i] = mem_q[i].valid && (mem_q[i].addr[31:2] == match_word_i);
  end

`ifdef DM_ARB_FWD_EN
  logic [PW-1:0] idx;
  // Walk oldest to youngest so the last hit wins.
  always_comb begin
    idx         = '0;
    fwd_hit_o   = 1'b0;
    fwd_wdata_o = '0;
    fwd_wmask_o = MASK_NONE;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (match_o[idx]) begin
        fwd_hit_o   = 1'b1;
        fwd_wdata_o = mem_q[idx].wdata;
        fwd_wmask_o = mem_q[idx].wmask;
      end
    end
  end
`endif

endmodule

// File: rtl/dm_port_arbiter.sv
// Single-port DM arbiter: loads first, buffered stores drained when idle, full, conflicting or starved.
// Define DM_ARB_FWD_EN to forward full-word buffered stores to conflicting loads.
module dm_port_arbiter
  import dm_port_arbiter_pkg::*;
#(
  parameter int WB_DEPTH   = 4,
  parameter int STARVE_MAX = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_req_valid,
  input  logic [31:0] ld_req_addr,
  output logic        ld_req_ready,
  input  logic        ld_kill,
  output logic        ld_rsp_valid,
  output logic [31:0] ld_rsp_data,
  input  logic        st_req_valid,
  input  logic [31:0] st_req_addr,
  input  logic [31:0] st_req_wdata,
  input  logic [31:0] st_req_wmask,
  output logic        st_req_ready,
  output logic        wb_empty,
  input  logic [31:0] DM_rd_data,
  output logic        DM_r_en,
  output logic [31:0] DM_w_en,
  output logic [31:0] DM_addr,
  output logic [31:0] DM_w_data
);

  localparam int CW = $clog2(WB_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  wb_entry_t         head;
  logic [CW-1:0]     count;
  logic [WB_DEPTH-1:0] match;
  logic [SW-1:0]     starve_q, starve_d;
  logic              rsp_valid_q, rsp_valid_d;
  grant_e            gnt;
  logic              wb_nonempty, wb_full, starved, enq;
  logic              st_conflict, conflict, drain, load_gnt, fwd_sel;

  // Valid head bit tracks non-empty exactly: pops clear it, pushes land at the tail.
  assign wb_nonempty  = head.valid;
  assign wb_full      = (count == CW'(WB_DEPTH));
  assign starved      = (starve_q == SW'(STARVE_MAX));
  assign st_req_ready = !wb_full;
  assign wb_empty     = !wb_nonempty;
  assign enq          = st_req_valid && st_req_ready;
  assign st_conflict  = enq && (st_req_addr[31:2] == ld_req_addr[31:2]);
  assign conflict     = ld_req_valid && ((|match) || st_conflict);

`ifdef DM_ARB_FWD_EN
  logic        fwd_hit, fwd_ok;
  logic [31:0] fwd_wdata, fwd_wmask;
  logic        fwd_q;
  logic [31:0] fwd_data_q;
`endif

  wb_fifo #(.DEPTH(WB_DEPTH)) u_wb (
    .clk          (clk),
    .rst          (rst),
    .push_i       (enq),
    .push_addr_i  (st_req_addr),
    .push_wdata_i (st_req_wdata),
    .push_wmask_i (st_req_wmask),
    .pop_i        (drain),
    .match_word_i (ld_req_addr[31:2]),
    .head_o       (head),
    .count_o      (count),
    .match_o      (match)
`ifdef DM_ARB_FWD_EN
    ,
    .fwd_hit_o    (fwd_hit),
    .fwd_wdata_o  (fwd_wdata),
    .fwd_wmask_o  (fwd_wmask)
`endif
  );

`ifdef DM_ARB_FWD_EN
  assign fwd_ok = ld_req_valid && fwd_hit && (fwd_wmask == '0) && !st_conflict;
`endif

  always_comb begin
    gnt     = GNT_IDLE;
    fwd_sel = 1'b0;
    if (!rst) begin
      if (wb_nonempty && (wb_full || starved || conflict)) gnt = GNT_DRAIN;
      else if (ld_req_valid && !conflict)                  gnt = GNT_LOAD;
      else if (wb_nonempty)                                gnt = GNT_DRAIN;
`ifdef DM_ARB_FWD_EN
      // Forwarded load rides along with a drain of the head entry.
      if (fwd_ok && !wb_full && !starved) begin
        gnt     = GNT_LOAD;
        fwd_sel = 1'b1;
      end
`endif
    end
  end

  assign drain        = (gnt == GNT_DRAIN) || fwd_sel;
  assign load_gnt     = (gnt == GNT_LOAD);
  assign ld_req_ready = load_gnt;

  always_comb begin
    DM_r_en   = 1'b0;
    DM_addr   = '0;
    DM_w_en   = MASK_NONE;
    DM_w_data = '0;
    if (drain) begin
      DM_addr   = head.addr;
      DM_w_en   = head.wmask;
      DM_w_data = head.wdata;
    end else if (load_gnt) begin
      DM_r_en = 1'b1;
      DM_addr = ld_req_addr;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!wb_nonempty || drain)        starve_d = '0;
    else if (load_gnt && !starved)    starve_d = starve_q + 1'b1;
    rsp_valid_d = load_gnt && !ld_kill;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q    <= '0;
      rsp_valid_q <= 1'b0;
`ifdef DM_ARB_FWD_EN
      fwd_q       <= 1'b0;
      fwd_data_q  <= '0;
`endif
    end else begin
      starve_q    <= starve_d;
      rsp_valid_q <= rsp_valid_d;
`ifdef DM_ARB_FWD_EN
      fwd_q       <= fwd_sel;
      fwd_data_q  <= fwd_wdata;
`endif
    end
  end

  assign ld_rsp_valid = rsp_valid_q;
`ifdef DM_ARB_FWD_EN
  assign ld_rsp_data  = fwd_q ? fwd_data_q : DM_rd_data;
`else
  assign ld_rsp_data  = DM_rd_data;
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Randomised bench for dm_port_arbiter against a queue-based reference of the write buffer and DM.
module tb_dm_port_arbiter;

  localparam int WB_DEPTH   = 4;
  localparam int STARVE_MAX = 7;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] wmask;
  } st_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ld_req_valid;
  logic [31:0] ld_req_addr;
  logic        ld_req_ready;
  logic        ld_kill;
  logic        ld_rsp_valid;
  logic [31:0] ld_rsp_data;
  logic        st_req_valid;
  logic [31:0] st_req_addr;
  logic [31:0] st_req_wdata;
  logic [31:0] st_req_wmask;
  logic        st_req_ready;
  logic        wb_empty;
  logic [31:0] DM_rd_data;
  logic        DM_r_en;
  logic [31:0] DM_w_en;
  logic [31:0] DM_addr;
  logic [31:0] DM_w_data;

  dm_port_arbiter #(.WB_DEPTH(WB_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk          (clk),
    .rst          (rst),
    .ld_req_valid (ld_req_valid),
    .ld_req_addr  (ld_req_addr),
    .ld_req_ready (ld_req_ready),
    .ld_kill      (ld_kill),
    .ld_rsp_valid (ld_rsp_valid),
    .ld_rsp_data  (ld_rsp_data),
    .st_req_valid (st_req_valid),
    .st_req_addr  (st_req_addr),
    .st_req_wdata (st_req_wdata),
    .st_req_wmask (st_req_wmask),
    .st_req_ready (st_req_ready),
    .wb_empty     (wb_empty),
    .DM_rd_data   (DM_rd_data),
    .DM_r_en      (DM_r_en),
    .DM_w_en      (DM_w_en),
    .DM_addr      (DM_addr),
    .DM_w_data    (DM_w_data)
  );

  // DM macro model: 256 words, seeded on reset, one-cycle read latency.
  logic [31:0] dm_mem [256];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) dm_mem[i] <= 32'hC0DE_0000 + i;
    end else begin
      if (DM_r_en) DM_rd_data <= dm_mem[DM_addr[9:2]];
      if (DM_w_en != 32'hFFFF_FFFF)
        dm_mem[DM_addr[9:2]] <= (dm_mem[DM_addr[9:2]] & DM_w_en) | (DM_w_data & ~DM_w_en);
    end
  end

  // scoreboard / reference state
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  st_t         wbq[$];
  logic [31:0] ref_mem [256];
  int          starve = 0;
  logic        exp_rsp_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: inputs are already driven; predict, compare, advance the model.
  task automatic cycle();
    logic        nonempty, full, enq, conf, do_drain, do_load;
    logic [31:0] e_addr, e_wen, e_wdata, d;
    st_t         h;
    @(negedge clk);
    check("rsp_valid", {31'b0, ld_rsp_valid}, {31'b0, exp_rsp_valid});
    if (exp_rsp_valid && exp_q.size() != 0) begin
      d = exp_q.pop_front();
      check("rsp_data", ld_rsp_data, d);
    end
    if (rst) begin
      check("rst_w_en", DM_w_en, 32'hFFFF_FFFF);
      check("rst_r_en", {31'b0, DM_r_en}, 32'h0);
      check("rst_ld_ready", {31'b0, ld_req_ready}, 32'h0);
      wbq.delete();
      exp_q.delete();
      starve        = 0;
      exp_rsp_valid = 1'b0;
      for (int i = 0; i < 256; i++) ref_mem[i] = 32'hC0DE_0000 + i;
    end else begin
      nonempty = (wbq.size() != 0);
      full     = (wbq.size() == WB_DEPTH);
      enq      = st_req_valid && !full;
      conf     = 1'b0;
      foreach (wbq[i]) if (wbq[i].addr[31:2] == ld_req_addr[31:2]) conf = 1'b1;
      if (enq && st_req_addr[31:2] == ld_req_addr[31:2]) conf = 1'b1;
      conf     = conf && ld_req_valid;
      do_drain = nonempty && (full || starve == STARVE_MAX || conf);
      do_load  = !do_drain && ld_req_valid && !conf;
      if (!do_drain && !do_load && nonempty) do_drain = 1'b1;

      e_addr = 32'h0; e_wen = 32'hFFFF_FFFF; e_wdata = 32'h0;
      if (do_drain) begin
        h = wbq[0];
        e_addr = h.addr; e_wen = h.wmask; e_wdata = h.wdata;
      end else if (do_load) begin
        e_addr = ld_req_addr;
      end
      check("ld_ready", {31'b0, ld_req_ready}, {31'b0, do_load});
      check("dm_r_en", {31'b0, DM_r_en}, {31'b0, do_load});
      check("dm_addr", DM_addr, e_addr);
      check("dm_w_en", DM_w_en, e_wen);
      check("dm_w_data", DM_w_data, e_wdata);
      check("st_ready", {31'b0, st_req_ready}, {31'b0, !full});
      check("wb_empty", {31'b0, wb_empty}, {31'b0, !nonempty});

      if (do_drain) begin
        ref_mem[h.addr[9:2]] = (ref_mem[h.addr[9:2]] & h.wmask) | (h.wdata & ~h.wmask);
        void'(wbq.pop_front());
      end
      if (do_load && !ld_kill) exp_q.push_back(ref_mem[ld_req_addr[9:2]]);
      exp_rsp_valid = do_load && !ld_kill;
      if (enq) wbq.push_back('{addr: st_req_addr, wdata: st_req_wdata, wmask: st_req_wmask});
      if (!nonempty || do_drain) starve = 0;
      else if (do_load && starve < STARVE_MAX) starve++;
    end
    @(posedge clk);
    #1;
  endtask

  // driver task
  task automatic drive(input logic r, input logic lv, input logic [31:0] la, input logic k,
                       input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic [31:0] sm);
    rst = r; ld_req_valid = lv; ld_req_addr = la; ld_kill = k;
    st_req_valid = sv; st_req_addr = sa; st_req_wdata = sd; st_req_wmask = sm;
    cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF);
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF);
    drive(1, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF);
    idle(1);

    // single store, no loads
    drive(0, 0, 0, 0, 1, 32'h100, 32'hDEAD_BEEF, 32'h0);
    idle(2);

    // one buffered store under continuous loads: starvation drain
    drive(0, 1, 32'h010, 0, 1, 32'h300, 32'h1234_5678, 32'h0);
    for (int i = 0; i < 11; i++) drive(0, 1, 32'h020 + 4 * (i % 4), 0, 0, 0, 0, 32'hFFFF_FFFF);
    idle(1);

    // conflicting load stalls until the matching store drains
    drive(0, 0, 0, 0, 1, 32'h200, 32'hDEAD_BEEF, 32'h0);
    for (int i = 0; i < 3; i++) drive(0, 1, 32'h202, 0, 0, 0, 0, 32'hFFFF_FFFF);
    idle(2);

    // fill the buffer under continuous loads
    for (int i = 0; i < 7; i++)
      drive(0, 1, 32'h040 + 4 * i, 0, 1, 32'h380 + 4 * i, 32'hA000_0000 + i, 32'h0000_FFFF);
    idle(6);

    // killed load
    drive(0, 1, 32'h0C0, 1, 0, 0, 0, 32'hFFFF_FFFF);
    idle(2);

    // reset with three stores buffered
    for (int i = 0; i < 3; i++)
      drive(0, 1, 32'h050 + 4 * i, 0, 1, 32'h3C0 + 4 * i, 32'hB000_0000 + i, 32'h0);
    drive(1, 1, 32'h060, 0, 0, 0, 0, 32'hFFFF_FFFF);
    idle(3);

    // random traffic over a small address pool to provoke conflicts
    for (int n = 0; n < 2000; n++) begin
      logic [31:0] m;
      case ($urandom_range(0, 4))
        0:       m = 32'h0;
        1:       m = 32'hFFFF_0000;
        2:       m = 32'h0000_FFFF;
        3:       m = $urandom;
        default: m = 32'hFFFF_FFFF;
      endcase
      drive($urandom_range(0, 249) == 0,
            $urandom_range(0, 99) < 60,
            32'h100 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3),
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 99) < 35,
            32'h100 + ($urandom_range(0, 15) << 2),
            $urandom, m);
    end
    idle(8);
    check("exp_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
